poly_voice_synth: RTL

Polyphonic note engine. It accepts note-on and note-off commands as note code plus octave, allocates them to `VOICES` square-wave voice slots, and emits a registered, signed, mixed sample each clock. It sits between the keyboard/control FSM and the audio codec path, replacing single-note frequency lookup with multi-note playback, retrigger and oldest-voice stealing.

---
 rtl/synth_pkg.sv | 48 ++++
 rtl/tone_voice.sv | 58 +++++
 rtl/poly_voice_synth.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the polyphonic note engine:
// note codes, octave-0 pitch table and half-period helper.
package synth_pkg;

  localparam logic [3:0] NOTE_A    = 4'd0;
  localparam logic [3:0] NOTE_AS   = 4'd1;
  localparam logic [3:0] NOTE_B    = 4'd2;
  localparam logic [3:0] NOTE_C    = 4'd3;
  localparam logic [3:0] NOTE_CS   = 4'd4;
  localparam logic [3:0] NOTE_D    = 4'd5;
  localparam logic [3:0] NOTE_DS   = 4'd6;
  localparam logic [3:0] NOTE_E    = 4'd7;
  localparam logic [3:0] NOTE_F    = 4'd8;
  localparam logic [3:0] NOTE_FS   = 4'd9;
  localparam logic [3:0] NOTE_G    = 4'd10;
  localparam logic [3:0] NOTE_GS   = 4'd11;
  localparam logic [3:0] NOTE_NULL = 4'd15;

  // Octave-0 frequencies in mHz, A0 = 27.5 Hz upward
  localparam int unsigned F0_MHZ [12] = '{
    27500, 29135, 30868, 32703, 34648, 36708,
    38891, 41203, 43654, 46249, 48999, 51913
  };

  function automatic int unsigned h0(
    int unsigned clk_hz,
    int unsigned n
  );
    longint unsigned num;
    longint unsigned den;
    den = 64'(F0_MHZ[n]) * 2;
    num = 64'(clk_hz) * 1000 + 64'(F0_MHZ[n]);
    return 32'(num / den);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY
  } state_t;

  typedef struct packed {
    logic       on;
    logic [3:0] note;
    logic [2:0] octave;
  } cmd_t;

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice slot: free-running half-period counter,
// phase, amplitude and note tag with load/clear strobes.
module tone_voice #(
  parameter int AMP_W = 8,
  parameter int CNT_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [3:0]              note,
  input  logic [2:0]              octave,
  input  logic [AMP_W-1:0]        vel,
  input  logic [CNT_W-1:0]        reload,
  output logic                    active,
  output logic [3:0]              tag_note,
  output logic [2:0]              tag_octave,
  output logic signed [AMP_W:0]   contrib
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rld;
  logic             phase;
  logic [AMP_W-1:0] amp;
  logic signed [AMP_W:0] mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rld        <= '0;
      phase      <= 1'b0;
      amp        <= '0;
      active     <= 1'b0;
      tag_note   <= '0;
      tag_octave <= '0;
    end else if (load) begin
      cnt        <= reload;
      rld        <= reload;
      phase      <= 1'b1;
      amp        <= vel;
      active     <= 1'b1;
      tag_note   <= note;
      tag_octave <= octave;
    end else begin
      if (cnt == '0) begin
        phase <= ~phase;
        cnt   <= rld;
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (clear) active <= 1'b0;
    end
  end

  assign mag     = $signed({1'b0, amp});
  assign contrib = !active ? '0 : (phase ? mag : -mag);

endmodule

// File: rtl/poly_voice_synth.sv
// Polyphonic note engine: command FSM, voice allocation with
// retrigger / lowest-free / LRU stealing, and registered mixer.
module poly_voice_synth
  import synth_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int VOICES = 4,
  parameter int AMP_W  = 8,
  localparam int OUT_W = AMP_W + $clog2(VOICES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              key_on,
  input  logic [3:0]        key_note,
  input  logic [2:0]        key_octave,
  input  logic [AMP_W-1:0]  key_vel,
  input  logic              panic,
  output logic [VOICES-1:0] voice_active,
  output logic [OUT_W-1:0]  sample_out
);

  localparam int CNT_W = $clog2(h0(CLK_HZ, 0) + 1);
  localparam int VW    = $clog2(VOICES);

  state_t           state;
  cmd_t             cmd;
  logic [AMP_W-1:0] cmd_vel;
  logic [VW-1:0]    tgt;
  logic             do_load;
  logic             do_clear;
  logic [CNT_W-1:0] reload;
  logic             accept;
  logic             apply_ok;

  logic [CNT_W-1:0] h0_rom [16];
  logic [VW-1:0]    rank [VOICES];
  logic [3:0]       tag_note [VOICES];
  logic [2:0]       tag_oct [VOICES];
  logic signed [AMP_W:0] contrib [VOICES];
  logic [VOICES-1:0] load;
  logic [VOICES-1:0] clear;

  logic          m_hit;
  logic          f_hit;
  logic [VW-1:0] m_idx;
  logic [VW-1:0] f_idx;
  logic [VW-1:0] v_idx;
  logic signed [OUT_W-1:0] mix;

  for (genvar g = 0; g < 16; g++) begin : g_rom
    if (g < 12) begin : g_note
      assign h0_rom[g] = CNT_W'(h0(CLK_HZ, g));
    end else begin : g_null
      assign h0_rom[g] = '0;
    end
  end

  // Downward scan leaves the lowest index in each result
  always_comb begin
    m_hit = 1'b0;
    f_hit = 1'b0;
    m_idx = '0;
    f_idx = '0;
    v_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (voice_active[i] && tag_note[i] == cmd.note
          && tag_oct[i] == cmd.octave) begin
        m_hit = 1'b1;
        m_idx = VW'(i);
      end
      if (!voice_active[i]) begin
        f_hit = 1'b1;
        f_idx = VW'(i);
      end
      if (rank[i] == VW'(VOICES - 1)) v_idx = VW'(i);
    end
  end

  assign accept = key_valid & key_ready & ~panic;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      key_ready <= 1'b0;
      cmd       <= '0;
      cmd_vel   <= '0;
      tgt       <= '0;
      do_load   <= 1'b0;
      do_clear  <= 1'b0;
      reload    <= '0;
    end else if (panic) begin
      state     <= S_IDLE;
      key_ready <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          key_ready <= ~accept;
          if (accept) begin
            cmd     <= {key_on, key_note, key_octave};
            cmd_vel <= key_vel;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          do_load  <= cmd.on & (cmd.note <= NOTE_GS);
          do_clear <= ~cmd.on & m_hit;
          tgt      <= (!cmd.on || m_hit) ? m_idx
                    : (f_hit ? f_idx : v_idx);
          reload   <= (h0_rom[cmd.note] >> cmd.octave) - 1'b1;
          state    <= S_APPLY;
        end
        S_APPLY: begin
          state     <= S_IDLE;
          key_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign apply_ok = (state == S_APPLY) & ~panic;

  always_comb begin
    load  = '0;
    clear = '0;
    for (int v = 0; v < VOICES; v++) begin
      load[v]  = apply_ok & do_load & (tgt == VW'(v));
      clear[v] = panic | (apply_ok & do_clear & (tgt == VW'(v)));
    end
  end

  // LRU ranks: written voice becomes 0, younger ones age by one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) rank[i] <= VW'(i);
    end else if (apply_ok && do_load) begin
      for (int i = 0; i < VOICES; i++) begin
        if (VW'(i) == tgt) rank[i] <= '0;
        else if (rank[i] < rank[tgt]) rank[i] <= rank[i] + 1'b1;
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    tone_voice #(
      .AMP_W(AMP_W),
      .CNT_W(CNT_W)
    ) u_voice (
      .clk       (clk),
      .rst       (reset),
      .load      (load[v]),
      .clear     (clear[v]),
      .note      (cmd.note),
      .octave    (cmd.octave),
      .vel       (cmd_vel),
      .reload    (reload),
      .active    (voice_active[v]),
      .tag_note  (tag_note[v]),
      .tag_octave(tag_oct[v]),
      .contrib   (contrib[v])
    );
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < VOICES; i++) mix = mix + OUT_W'(contrib[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sample_out <= '0;
    else       sample_out <= mix;
  end

endmodule
